// File: rtl/fifo_uart_tx.sv
// Serial transmitter fed from a registered-read sync FIFO: pops one byte per frame and
// sends start, 8 data bits LSB-first, optional parity and one stop bit on tx.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift_reg, shift_n;
    logic          parity_bit, parity_n;
    logic          tx_n, rd_en_n, busy_n, done_n;
    logic          baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_idx    <= bit_n;
            shift_reg  <= shift_n;
            parity_bit <= parity_n;
            tx         <= tx_n;
            fifo_rd_en <= rd_en_n;
            busy       <= busy_n;
            byte_done  <= done_n;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        shift_n  = shift_reg;
        parity_n = parity_bit;

        unique case (state)
            IDLE: begin
                if (tx_en && !fifo_empty) state_n = FETCH;
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                shift_n  = fifo_data;
                parity_n = PARITY_ODD ? ~^fifo_data : ^fifo_data;
                baud_n   = '0;
                state_n  = START;
            end
            START, DATA, PARITY, STOP: begin
                baud_n = baud_last ? '0 : baud_cnt + BW'(1);
                if (baud_last) begin
                    unique case (state)
                        START: begin
                            bit_n   = '0;
                            state_n = DATA;
                        end
                        DATA: begin
                            if (bit_idx == 3'd7) begin
                                bit_n   = '0;
                                state_n = PARITY_EN ? PARITY : STOP;
                            end else begin
                                bit_n   = bit_idx + 3'd1;
                                shift_n = {1'b0, shift_reg[7:1]};
                            end
                        end
                        PARITY:  state_n = STOP;
                        default: state_n = IDLE;
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered without lag.
        unique case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            PARITY:  tx_n = parity_n;
            default: tx_n = 1'b1;
        endcase
        rd_en_n = (state_n == FETCH);
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == STOP) && (baud_n == BAUD_LAST);
    end

endmodule
